config_sequencer: RTL and testbench

CONFIG_SEQUENCER -- requirements
Module: config_sequencer

---
 rtl/config_sequencer_if.sv | 13 +
 rtl/config_sequencer.sv | 71 +++++++
 tb/tb_config_sequencer.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/config_sequencer_if.sv
// config_sequencer_if: host command channel plus the tracing/config broadcast bundle
interface config_sequencer_if;
  logic cmd_valid, cmd_ready, cmd_last, tracing_req, tracing, busy;
  logic [7:0] cmd_id, cmd_data, configId, configData;
  modport master (
    output cmd_valid, cmd_id, cmd_data, cmd_last, tracing_req,
    input cmd_ready, tracing, configId, configData, busy
  );
  modport slave (
    input cmd_valid, cmd_id, cmd_data, cmd_last, tracing_req,
    output cmd_ready, tracing, configId, configData, busy
  );
endinterface

// File: rtl/config_sequencer.sv
// config_sequencer: queues host config writes and broadcasts them inside a tracing-quiet window
module config_sequencer #(
  parameter int FIFO_DEPTH = 4,
  parameter int DRAIN_CYCLES = 4
) (
  input logic clk,
  input logic reset,
  config_sequencer_if.slave bus
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int DW = $clog2(DRAIN_CYCLES + 1);
  typedef enum logic [1:0] {IDLE, DRAIN, WRITE, RESUME} state_t;
  state_t state;
  logic [16:0] mem [FIFO_DEPTH];
  logic [16:0] head;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0] count;
  logic [DW-1:0] drain_cnt;
  logic last_seen, full, empty, push, pop;
  assign full = count == (AW+1)'(FIFO_DEPTH);
  assign empty = count == '0;
  assign push = bus.cmd_valid && !full;
  // once the last entry has gone out, later entries wait for the next burst
  assign pop = state == WRITE && !last_seen && !empty;
  assign head = mem[rd_ptr];
  assign bus.cmd_ready = !full;
  assign bus.busy = state != IDLE;
  always_ff @(posedge clk) if (push) mem[wr_ptr] <= {bus.cmd_id, bus.cmd_data, bus.cmd_last};
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
      drain_cnt <= '0;
      last_seen <= 1'b0;
      bus.tracing <= 1'b0;
      bus.configId <= '0;
      bus.configData <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + (AW+1)'(push) - (AW+1)'(pop);
      bus.configId <= pop ? head[16:9] : '0;
      if (pop && head[16:9] != '0) bus.configData <= head[8:1];
      bus.tracing <= 1'b0;
      case (state)
        IDLE: begin
          if (!empty) begin
            state <= DRAIN;
            drain_cnt <= DW'(DRAIN_CYCLES - 1);
          end else bus.tracing <= bus.tracing_req;
        end
        DRAIN: begin
          drain_cnt <= drain_cnt - 1'b1;
          if (drain_cnt == '0) state <= WRITE;
        end
        WRITE: begin
          if (last_seen) state <= RESUME;
          else if (pop && head[0]) last_seen <= 1'b1;
        end
        RESUME: begin
          state <= IDLE;
          last_seen <= 1'b0;
          bus.tracing <= bus.tracing_req;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_config_sequencer.sv
// tb_config_sequencer: burst timeline model (push edges -> pop edges -> pulses) against the sequencer
module tb_config_sequencer;
  localparam int DEPTH = 4;
  localparam int D = 4;
  logic clk = 1'b0;
  logic reset;
  int total = 0;
  int bad = 0;
  logic [7:0] exp_data;
  logic [7:0] ids [4];
  logic [7:0] dats [4];
  int push_at [4];
  int pop_at [4];
  config_sequencer_if bus ();
  config_sequencer #(.FIFO_DEPTH(DEPTH), .DRAIN_CYCLES(D)) dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  always @(negedge clk) begin
    total++;
    assert (!(bus.tracing && bus.configId != 8'd0)) else begin
      bad++;
      $error("FAIL trace_vs_cfg: observed tracing=%0b configId=%0h expected tracing=0", bus.tracing, bus.configId);
    end
  end
  // entry k pops one edge after it lands, no earlier than the first WRITE cycle, one per edge
  task automatic run_burst(input int n, input logic treq);
    int last, cnt;
    logic [7:0] eid;
    bus.tracing_req = treq;
    tick();
    tick();
    for (int k = 0; k < n; k++)
      pop_at[k] = (k == 0) ? D + 2 : ((pop_at[k-1] + 1 > push_at[k] + 1) ? pop_at[k-1] + 1 : push_at[k] + 1);
    last = pop_at[n-1];
    for (int c = 0; c <= last + 3; c++) begin
      bus.cmd_valid = 1'b0;
      for (int k = 0; k < n; k++)
        if (push_at[k] == c) begin
          bus.cmd_valid = 1'b1;
          bus.cmd_id = ids[k];
          bus.cmd_data = dats[k];
          bus.cmd_last = (k == n - 1);
        end
      tick();
      eid = 8'd0;
      cnt = 0;
      for (int k = 0; k < n; k++) begin
        if (pop_at[k] == c) begin
          eid = ids[k];
          if (ids[k] != 8'd0) exp_data = dats[k];
        end
        cnt += int'(push_at[k] <= c) - int'(pop_at[k] <= c);
      end
      check("configId", 32'(bus.configId), 32'(eid));
      check("configData", 32'(bus.configData), 32'(exp_data));
      check("busy", 32'(bus.busy), 32'(c >= 1 && c <= last + 1));
      check("tracing", 32'(bus.tracing), 32'((c == 0 || c >= last + 2) ? treq : 1'b0));
      check("cmd_ready", 32'(bus.cmd_ready), 32'(cnt < DEPTH));
    end
    bus.cmd_valid = 1'b0;
  endtask
  initial begin
    reset = 1'b1;
    exp_data = 8'd0;
    bus.cmd_valid = 1'b0;
    bus.cmd_id = 8'd0;
    bus.cmd_data = 8'd0;
    bus.cmd_last = 1'b0;
    bus.tracing_req = 1'b1;
    tick();
    tick();
    check("rst_tracing", 32'(bus.tracing), 32'd0);
    check("rst_configId", 32'(bus.configId), 32'd0);
    check("rst_configData", 32'(bus.configData), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    reset = 1'b0;
    tick();
    check("rst_ready", 32'(bus.cmd_ready), 32'd1);
    for (int c = 0; c < 3; c++) begin
      check("idle_tracing", 32'(bus.tracing), 32'd1);
      check("idle_busy", 32'(bus.busy), 32'd0);
      check("idle_configId", 32'(bus.configId), 32'd0);
      tick();
    end
    bus.tracing_req = 1'b0;
    tick();
    check("idle_tracing_off", 32'(bus.tracing), 32'd0);
    ids[0] = 8'd5; dats[0] = 8'h12; push_at[0] = 0;
    run_burst(1, 1'b1);
    for (int k = 0; k < 4; k++) begin
      ids[k] = 8'h40 + 8'(k);
      dats[k] = 8'ha0 + 8'(k);
      push_at[k] = k;
    end
    run_burst(4, 1'b1);
    ids[0] = 8'h61; dats[0] = 8'h71; push_at[0] = 0;
    ids[1] = 8'h62; dats[1] = 8'h72; push_at[1] = 1;
    ids[2] = 8'h63; dats[2] = 8'h73; push_at[2] = D + 2 + 2 + 3;
    run_burst(3, 1'b1);
    ids[0] = 8'd0; dats[0] = 8'h55; push_at[0] = 0;
    run_burst(1, 1'b1);
    bus.tracing_req = 1'b0;
    tick();
    tick();
    for (int c = 0; c <= D + 2; c++) begin
      bus.cmd_valid = (c < 3);
      bus.cmd_id = 8'h21 + 8'(c);
      bus.cmd_data = 8'h31 + 8'(c);
      bus.cmd_last = (c == 2);
      tick();
    end
    check("pre_rst_configId", 32'(bus.configId), 32'h21);
    check("pre_rst_configData", 32'(bus.configData), 32'h31);
    reset = 1'b1;
    bus.cmd_valid = 1'b1;
    bus.cmd_id = 8'h44;
    bus.cmd_last = 1'b1;
    tick();
    reset = 1'b0;
    bus.cmd_valid = 1'b0;
    exp_data = 8'd0;
    check("mid_rst_configId", 32'(bus.configId), 32'd0);
    check("mid_rst_configData", 32'(bus.configData), 32'd0);
    check("mid_rst_tracing", 32'(bus.tracing), 32'd0);
    check("mid_rst_busy", 32'(bus.busy), 32'd0);
    check("mid_rst_ready", 32'(bus.cmd_ready), 32'd1);
    for (int c = 0; c < D + 6; c++) begin
      tick();
      check("post_rst_configId", 32'(bus.configId), 32'd0);
      check("post_rst_busy", 32'(bus.busy), 32'd0);
    end
    for (int b = 0; b < 15; b++) begin
      int n;
      n = int'($urandom_range(1, 4));
      for (int k = 0; k < n; k++) begin
        ids[k] = ($urandom_range(0, 3) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
        dats[k] = 8'($urandom_range(0, 255));
        push_at[k] = (k == 0) ? 0 : push_at[k-1] + int'($urandom_range(1, 3));
      end
      run_burst(n, 1'($urandom_range(0, 1)));
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
